// File: rtl/caliptra_apb_initiator_pkg.sv
// Shared types and constants for the Caliptra APB initiator.
// Holds the FSM state encoding, timeout counter width and default PPROT.
package caliptra_apb_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int TMO_CNT_W = 16;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/caliptra_apb_initiator.sv
// APB requester: turns valid/ready commands into single APB transfers and
// returns rdata/err on a valid/ready response channel, one transfer at a time.
// Ports: core_clk/core_rst (async, active-high); cmd_* command channel;
// rsp_* response channel; P* APB requester signals (all registered).
// Option: define CALIPTRA_APB_INITIATOR_TIMEOUT_EN to abort ACCESS phases
// after TIMEOUT_CYCLES wait cycles (rsp_timeout is tied to 0 otherwise).
module caliptra_apb_initiator
    import caliptra_apb_initiator_pkg::*;
#(
    parameter int         ADDR_W         = 32,
    parameter int         DATA_W         = 32,
    parameter int         USER_W         = 32,
    parameter logic [2:0] PPROT_VAL      = PPROT_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 256
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [USER_W-1:0] cmd_user,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic [2:0]        PPROT,
    output logic [USER_W-1:0] PAUSER,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (2 ** TMO_CNT_W) - 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..65535");
    end

    apb_state_e state;
    logic       tmo_hit;

    assign PPROT     = PPROT_VAL;
    assign cmd_ready = (state == ST_IDLE);

`ifdef CALIPTRA_APB_INITIATOR_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_CNT_W-1:0] tmo_cnt;
    logic                 tmo_q;

    // Abort only when the slave is still stalling on the final allowed edge;
    // a PREADY on that edge completes normally.
    assign tmo_hit     = !PREADY && (tmo_cnt == TMO_LAST);
    assign rsp_timeout = tmo_q;

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            if (state == ST_SETUP) begin
                tmo_cnt <= '0;
            end else if (state == ST_ACCESS && !PREADY) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (state == ST_ACCESS) begin
                if (PREADY) begin
                    tmo_q <= 1'b0;
                end else if (tmo_hit) begin
                    tmo_q <= 1'b1;
                end
            end
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state     <= ST_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PAUSER    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        PWRITE <= cmd_write;
                        PADDR  <= cmd_addr;
                        PWDATA <= cmd_wdata;
                        PAUSER <= cmd_user;
                        PSEL   <= 1'b1;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        // Writes and errored reads return zero data.
                        rsp_rdata <= (PWRITE || PSLVERR) ? '0 : PRDATA;
                        rsp_err   <= PSLVERR;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (tmo_hit) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_caliptra_apb_initiator.sv
// Self-checking bench for caliptra_apb_initiator.
// Table vectors, hand sequences and random transfers against a transfer model.
module tb_caliptra_apb_initiator;

    localparam int         TMO   = 4;
    localparam logic [2:0] PPROT_EXP = 3'b101;

    logic        core_clk;
    logic        core_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [31:0] cmd_user;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] PADDR;
    logic [2:0]  PPROT;
    logic [31:0] PAUSER;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_vec = 0;
    int n_err = 0;

    caliptra_apb_initiator #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .USER_W        (32),
        .PPROT_VAL     (PPROT_EXP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .core_clk   (core_clk),
        .core_rst   (core_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_user   (cmd_user),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR      (PADDR),
        .PPROT      (PPROT),
        .PAUSER     (PAUSER),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] user;
        logic [31:0] prdata;
        logic        slverr;
        int          waits;
        int          rsp_delay;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_tmo;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what a transfer must return, from the protocol rules.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        logic tmo;
        r   = v;
        tmo = 1'b0;
`ifdef CALIPTRA_APB_INITIATOR_TIMEOUT_EN
        tmo = (v.waits >= TMO);
`endif
        r.exp_tmo   = tmo;
        r.exp_err   = tmo || v.slverr;
        r.exp_rdata = (tmo || v.slverr || v.write) ? 32'h0 : v.prdata;
        return r;
    endfunction

    task automatic chk_apb(input string ph, input vec_t v);
        chk({ph, "_paddr"}, PADDR, v.addr);
        chk({ph, "_pwdata"}, PWDATA, v.wdata);
        chk({ph, "_pauser"}, PAUSER, v.user);
        chk({ph, "_pwrite"}, 32'(PWRITE), 32'(v.write));
    endtask

    task automatic chk_rsp(input string ph, input vec_t v);
        chk({ph, "_rsp_valid"}, 32'(rsp_valid), 1);
        chk({ph, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({ph, "_rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({ph, "_rsp_timeout"}, 32'(rsp_timeout), 32'(v.exp_tmo));
        chk({ph, "_cmd_ready"}, 32'(cmd_ready), 0);
        chk({ph, "_psel"}, 32'(PSEL), 0);
        chk({ph, "_penable"}, 32'(PENABLE), 0);
    endtask

    // Runs one transfer; must be entered just after a negedge in IDLE.
    task automatic xfer(input vec_t v);
        int acc;
        acc = v.exp_tmo ? TMO : v.waits + 1;
        chk("idle_cmd_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_user  = v.user;
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        for (int k = 0; k <= acc + 1; k++) begin
            @(negedge core_clk);
            if (k == 0) begin
                chk("setup_psel", 32'(PSEL), 1);
                chk("setup_penable", 32'(PENABLE), 0);
                chk("setup_rsp_valid", 32'(rsp_valid), 0);
                chk("setup_cmd_ready", 32'(cmd_ready), 0);
                chk_apb("setup", v);
                // Held-but-changing command must be ignored.
                cmd_write = $urandom;
                cmd_addr  = $urandom;
                cmd_wdata = $urandom;
                cmd_user  = $urandom;
                PREADY    = $urandom;
                PSLVERR   = $urandom;
                PRDATA    = $urandom;
            end else if (k <= acc) begin
                chk("access_psel", 32'(PSEL), 1);
                chk("access_penable", 32'(PENABLE), 1);
                chk("access_rsp_valid", 32'(rsp_valid), 0);
                chk("access_cmd_ready", 32'(cmd_ready), 0);
                chk_apb("access", v);
                if (k - 1 == v.waits) begin
                    PREADY  = 1'b1;
                    PRDATA  = v.prdata;
                    PSLVERR = v.slverr;
                end else begin
                    PREADY  = 1'b0;
                    PRDATA  = $urandom;
                    PSLVERR = $urandom;
                end
            end else begin
                chk_rsp("resp", v);
                chk_apb("resp", v);
                PREADY  = $urandom;
                PRDATA  = $urandom;
                PSLVERR = $urandom;
            end
        end
        for (int d = 0; d < v.rsp_delay; d++) begin
            @(negedge core_clk);
            chk_rsp("bp", v);
        end
        rsp_ready = 1'b1;
        @(negedge core_clk);
        chk("done_rsp_valid", 32'(rsp_valid), 0);
        chk("done_cmd_ready", 32'(cmd_ready), 1);
        chk("done_psel", 32'(PSEL), 0);
        chk_apb("done", v);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] u, input logic [31:0] pr, input logic e,
                                input int ws, input int dl);
        vec_t v;
        v.write     = w;
        v.addr      = a;
        v.wdata     = d;
        v.user      = u;
        v.prdata    = pr;
        v.slverr    = e;
        v.waits     = ws;
        v.rsp_delay = dl;
        v.exp_rdata = '0;
        v.exp_err   = 1'b0;
        v.exp_tmo   = 1'b0;
        return v;
    endfunction

    vec_t tbl[5];

    initial begin
        vec_t v;

        tbl[0] = '{1'b0, 32'h3002_0000, 32'h0, 32'h1, 32'hCAFE_F00D, 1'b0, 0, 0,
                   32'hCAFE_F00D, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'h3002_0008, 32'h1234_5678, 32'hFFFF_FFFF, 32'hDEAD_BEEF,
                   1'b0, 3, 0, 32'h0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 32'h3002_0010, 32'h0, 32'h2, 32'h55AA_55AA, 1'b1, 1, 0,
                   32'h0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 32'h3002_0014, 32'h0, 32'h3, 32'hA5A5_0001, 1'b0, 0, 10,
                   32'hA5A5_0001, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 32'h3002_0018, 32'h0BAD_0BAD, 32'h4, 32'h7777_7777, 1'b1, 2, 1,
                   32'h0, 1'b1, 1'b0};

        core_rst  = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_user  = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        @(negedge core_clk);
        @(negedge core_clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_psel", 32'(PSEL), 0);
        chk("rst_penable", 32'(PENABLE), 0);
        chk("rst_pwrite", 32'(PWRITE), 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_pauser", PAUSER, 0);
        chk("pprot", 32'(PPROT), 32'(PPROT_EXP));
        core_rst = 1'b0;
        @(negedge core_clk);

        for (int i = 0; i < 5; i++) begin
            xfer(tbl[i]);
        end

        // Long stall: aborts with the timeout option, completes without it.
        xfer(model(mk(1'b0, 32'h3002_0020, 32'h0, 32'h5, 32'h1357_9BDF, 1'b0, 10, 2)));
        // Ready on the last allowed ACCESS edge completes normally.
        xfer(model(mk(1'b0, 32'h3002_0024, 32'h0, 32'h6, 32'h2468_ACE0, 1'b0, TMO - 1, 0)));
        xfer(model(mk(1'b1, 32'h3002_0028, 32'hFACE_0001, 32'h7, 32'h0, 1'b0, TMO, 0)));

        // Asynchronous reset in the middle of ACCESS.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h3002_0030;
        cmd_wdata = 32'h1111_2222;
        cmd_user  = 32'h9;
        @(negedge core_clk);
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        @(negedge core_clk);
        chk("pre_rst_penable", 32'(PENABLE), 1);
        #2 core_rst = 1'b1;
        #1;
        chk("mid_rst_psel", 32'(PSEL), 0);
        chk("mid_rst_penable", 32'(PENABLE), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("mid_rst_paddr", PADDR, 0);
        #1 core_rst = 1'b0;
        @(negedge core_clk);
        xfer(model(mk(1'b0, 32'h3002_0034, 32'h0, 32'hA, 32'h0F0F_F0F0, 1'b0, 1, 0)));

        for (int i = 0; i < 40; i++) begin
            v = mk($urandom, $urandom, $urandom, $urandom, $urandom,
                   ($urandom_range(0, 3) == 0), $urandom_range(0, 6),
                   $urandom_range(0, 3));
            xfer(model(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/caliptra_apb_initiator.md
Name: caliptra_apb_initiator

Overview:
- APB requester: drives the Caliptra APB slave port (PADDR/PAUSER/PSEL/PENABLE/PWRITE/PWDATA) from a simple valid/ready command interface.
- Returns read data and error status on a valid/ready response interface.
- Used in the FPGA harness when a local sequencer, not the PS AXI-to-APB bridge, drives the mailbox and SoC registers.
- One transfer outstanding at a time.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- USER_W, 32, PAUSER width.
- PPROT_VAL, 3'b000, constant driven on PPROT.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase wait cycles. Only used with the optional feature. Legal range is 2..65535.

Ports:
- core_clk  in  1  sole clock.
- core_rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_user  in  USER_W  PAUSER value for this transfer.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accept.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PADDR  out  ADDR_W
- PPROT  out  3
- PAUSER  out  USER_W
- PSEL  out  1
- PENABLE  out  1
- PWRITE  out  1
- PWDATA  out  DATA_W
- PRDATA  in  DATA_W
- PREADY  in  1
- PSLVERR  in  1

Behaviour:
- Interface: one clock core_clk; asynchronous active-high reset core_rst.
- Reset values (applied immediately on core_rst assertion, including mid-transfer):
  - FSM = IDLE.
  - cmd_ready = 1.
  - rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE = 0.
  - PADDR, PAUSER, PWDATA, rsp_rdata = 0.
  - Timeout counter = 0.
- All APB outputs are registered. PPROT is the constant PPROT_VAL.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready: latch write/addr/wdata/user into PWRITE/PADDR/PWDATA/PAUSER, set PSEL = 1, go to SETUP.
- SETUP (exactly 1 cycle):
  - PSEL = 1, PENABLE = 0.
  - Next state is ACCESS with PENABLE = 1.
- ACCESS:
  - PSEL = PENABLE = 1. PADDR/PWDATA/PWRITE/PAUSER stay stable.
  - On a clock edge with PREADY = 1:
    - Capture rsp_rdata = PWRITE ? 0 : PRDATA.
    - rsp_err = PSLVERR; rsp_timeout = 0.
    - Force rsp_rdata = 0 if PSLVERR = 1.
    - PSEL = PENABLE = 0, rsp_valid = 1, go to RESP.
  - PREADY = 0: stay; the counter increments (optional feature).
- RESP:
  - cmd_ready = 0; rsp_* held stable.
  - On rsp_valid && rsp_ready: rsp_valid = 0, cmd_ready = 1, go to IDLE.
- cmd_ready is 0 in SETUP, ACCESS and RESP. cmd_valid in those states is ignored.
- Latency with zero-wait slave and rsp_ready held at 1:
  - Command handshake at edge N.
  - SETUP during cycle N+1, ACCESS during cycle N+2.
  - rsp_valid high in cycle N+3.
  - Next command accepted at edge N+4.
  - Each slave wait state adds 1 cycle.
- PADDR/PWDATA/PAUSER/PWRITE retain their last values after a transfer, until the next command.
- Back-pressure on rsp_ready blocks new commands indefinitely. No command loss.

Optional Feature:
- Macro: CALIPTRA_APB_INITIATOR_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0.
  - When the counter == TIMEOUT_CYCLES-1 and PREADY = 0 at an edge, abort: PSEL = PENABLE = 0, rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0, go to RESP.
  - PREADY = 1 on that same edge wins (normal completion).
- Undefined:
  - No counter; ACCESS waits forever.
  - rsp_timeout is tied to 0.

Decomposition:
- Package caliptra_apb_initiator_pkg holds:
  - FSM state enum (IDLE/SETUP/ACCESS/RESP, 2-bit).
  - Timeout counter width constant (16).
  - Default PPROT constant.
- No sub-module; the FSM and counter live in one module.

Test Plan:
- Zero-wait read: cmd read addr 0x3002_0000, PRDATA = 0xCAFE_F00D, PREADY = 1 → PSEL rises at N+1, PENABLE at N+2; rsp_valid at N+3 with rdata 0xCAFE_F00D, err = 0.
- Write with 3 wait states: cmd write 0x3002_0008 data 0x1234_5678 user 0xFFFF_FFFF → PWDATA/PAUSER stable through 3 PREADY = 0 cycles; rsp_valid at N+6, rdata = 0, err = 0.
- Slave error: read with PSLVERR = 1 at PREADY → rsp_err = 1, rsp_rdata = 0, rsp_timeout = 0.
- Response back-pressure: rsp_ready = 0 for 10 cycles with cmd_valid held → cmd_ready stays 0 and rsp fields are stable; second command accepted 1 cycle after the response handshake.
- Timeout (macro defined, TIMEOUT_CYCLES = 4): PREADY held 0 → abort after 4 ACCESS cycles; rsp_err = rsp_timeout = 1, PSEL = 0. Repeat with PREADY = 1 on the 4th ACCESS cycle → normal completion, timeout = 0.
- Reset mid-ACCESS: assert core_rst asynchronously → PSEL/PENABLE/rsp_valid drop before the next edge, cmd_ready = 1; the first post-reset command completes normally.
